hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_pkg.sv | 19 +
 rtl/fwd_select.sv | 26 ++
 rtl/hazard_forward_unit.sv | 123 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and types for the hazard detection / forwarding unit.
package hazard_pkg;

  localparam int unsigned FWD_W       = 2;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned STALL_CNT_W = 16;

  typedef logic [FWD_W-1:0] fwd_t;

  localparam fwd_t FWD_REG    = 2'b00;
  localparam fwd_t FWD_MEM_WB = 2'b01;
  localparam fwd_t FWD_EX_MEM = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding select: EX/MEM result beats MEM/WB, register 0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_regwrite,
  output fwd_t                  fwd
);

  // A load in MEM has no data yet, so it falls through to the MEM/WB check.
  always_comb begin
    fwd = FWD_REG;
    if (ex_mem_regwrite && !ex_mem_memread && (ex_mem_rd != '0) && (ex_mem_rd == src)) begin
      fwd = FWD_EX_MEM;
    end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == src)) begin
      fwd = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall controller with per-operand EX forwarding selects and a stall cycle counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    IF_ID_Src,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    ID_EX_Src,
  input  logic [REG_ADDR_W-1:0]            ID_EX_Rd,
  input  logic                             ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0]            EX_MEM_Rd,
  input  logic                             EX_MEM_RegWrite,
  input  logic                             EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0]            MEM_WB_Rd,
  input  logic                             MEM_WB_RegWrite,
  input  logic                             Flush,
  output logic [2*NUM_SRC-1:0]             Forward,
  output logic                             PC_Write,
  output logic                             IF_ID_Write,
  output logic                             ID_EX_Bubble,
  output logic [STALL_CNT_W-1:0]           Stall_Count
);

  // The first stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LAT-1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                    load_use;
  logic                    stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_select (
      .src             (ID_EX_Src[i*REG_ADDR_W +: REG_ADDR_W]),
      .ex_mem_rd       (EX_MEM_Rd),
      .ex_mem_regwrite (EX_MEM_RegWrite),
      .ex_mem_memread  (EX_MEM_MemRead),
      .mem_wb_rd       (MEM_WB_Rd),
      .mem_wb_regwrite (MEM_WB_RegWrite),
      .fwd             (Forward[2*i +: 2])
    );
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (ID_EX_Rd == IF_ID_Src[i*REG_ADDR_W +: REG_ADDR_W]) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && ID_EX_MemRead && (ID_EX_Rd != '0);
  end

  // Next state and stall decision; Flush overrides everything, reset releases the pipeline at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = CNT_INIT;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (reset) begin
      stall = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PC_Write     = ~stall;
  assign IF_ID_Write  = ~stall;
  assign ID_EX_Bubble = stall;
  assign Stall_Count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: reference model checked every cycle plus literal checks.
module tb_hazard_forward_unit;

  localparam int unsigned W  = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned LL = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*W-1:0]   if_id_src, id_ex_src;
  logic [W-1:0]      id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic              id_ex_memread, ex_mem_regwrite, ex_mem_memread, mem_wb_regwrite, flush;
  logic [2*NS-1:0]   forward;
  logic              pc_write, if_id_write, id_ex_bubble;
  logic [15:0]       stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REG_ADDR_W (W),
    .NUM_SRC    (NS),
    .LOAD_LAT   (LL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_Src       (if_id_src),
    .ID_EX_Src       (id_ex_src),
    .ID_EX_Rd        (id_ex_rd),
    .ID_EX_MemRead   (id_ex_memread),
    .EX_MEM_Rd       (ex_mem_rd),
    .EX_MEM_RegWrite (ex_mem_regwrite),
    .EX_MEM_MemRead  (ex_mem_memread),
    .MEM_WB_Rd       (mem_wb_rd),
    .MEM_WB_RegWrite (mem_wb_regwrite),
    .Flush           (flush),
    .Forward         (forward),
    .PC_Write        (pc_write),
    .IF_ID_Write     (if_id_write),
    .ID_EX_Bubble    (id_ex_bubble),
    .Stall_Count     (stall_count)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int rem_stall = 0;   // stall cycles still owed after the current one
  int exp_cnt   = 0;

  function automatic logic [1:0] m_fwd(input int i);
    logic [W-1:0] s;
    s = id_ex_src[i*W +: W];
    if (ex_mem_regwrite && !ex_mem_memread && ex_mem_rd != 0 && ex_mem_rd == s) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
    for (int i = 0; i < int'(NS); i++)
      if (id_ex_rd == if_id_src[i*W +: W]) h = 1;
    return h && id_ex_memread && id_ex_rd != 0;
  endfunction

  function automatic bit m_stall();
    return !reset && !flush && (rem_stall > 0 || m_hazard());
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_stall <= 0;
      exp_cnt   <= 0;
    end else begin
      if (m_stall() && exp_cnt < 65535) exp_cnt <= exp_cnt + 1;
      if (flush)               rem_stall <= 0;
      else if (rem_stall > 0)  rem_stall <= rem_stall - 1;
      else if (m_hazard())     rem_stall <= int'(LL) - 1;
    end
  end

  always @(negedge clk) begin
    logic [2*NS-1:0] ef;
    for (int i = 0; i < int'(NS); i++) ef[2*i +: 2] = m_fwd(i);
    check("model_forward", int'(forward), int'(ef));
    check("model_pc_write", int'(pc_write), int'(!m_stall()));
    check("model_if_id_write", int'(if_id_write), int'(!m_stall()));
    check("model_bubble", int'(id_ex_bubble), int'(m_stall()));
    check("model_stall_count", int'(stall_count), exp_cnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_id_src = '0; id_ex_src = '0; id_ex_rd = '0; id_ex_memread = 0;
    ex_mem_rd = '0; ex_mem_regwrite = 0; ex_mem_memread = 0;
    mem_wb_rd = '0; mem_wb_regwrite = 0; flush = 0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1;
    #2 reset = 0;
  endtask

  task automatic set_hazard();
    id_ex_memread = 1; id_ex_rd = 5'd7; if_id_src = {5'd7, 5'd2};
  endtask

  task automatic clr_hazard();
    id_ex_memread = 0; id_ex_rd = '0; if_id_src = '0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clk);
    check("reset_stall_count", int'(stall_count), 0);
    check("reset_pc_write", int'(pc_write), 1);
    check("reset_bubble", int'(id_ex_bubble), 0);
    next_cycle();
    reset = 0;

    // forwarding priority
    ex_mem_rd = 5'd3; mem_wb_rd = 5'd3; ex_mem_regwrite = 1; mem_wb_regwrite = 1;
    id_ex_src = {5'd3, 5'd3};
    @(negedge clk); check("fwd_both_exmem", int'(forward), 4'b1010);
    next_cycle(); ex_mem_regwrite = 0;
    @(negedge clk); check("fwd_both_memwb", int'(forward), 4'b0101);
    next_cycle(); ex_mem_regwrite = 1; mem_wb_rd = 5'd4; id_ex_src = {5'd4, 5'd3};
    @(negedge clk); check("fwd_mixed", int'(forward), 4'b0110);
    next_cycle(); ex_mem_rd = 5'd0; mem_wb_regwrite = 0; id_ex_src = {5'd9, 5'd0};
    @(negedge clk); check("fwd_rd_zero", int'(forward[1:0]), 2'b00);
    next_cycle(); ex_mem_memread = 1; ex_mem_rd = 5'd5; mem_wb_rd = 5'd5;
    mem_wb_regwrite = 1; id_ex_src = {5'd0, 5'd5};
    @(negedge clk); check("fwd_load_in_mem", int'(forward[1:0]), 2'b01);
    next_cycle(); clear_inputs();

    // load-use stall lasts exactly LOAD_LAT cycles
    set_hazard();
    begin
      int low = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_pc_pattern", int'(pc_write), (k < int'(LL)) ? 0 : 1);
        if (!pc_write) low++;
        next_cycle();
        if (k == 0) clr_hazard();
      end
      check("stall_low_cycles", low, 3);
    end
    @(negedge clk); check("stall_count_after", int'(stall_count), 3);

    // flush in the second stall cycle
    pulse_reset();
    next_cycle(); set_hazard();
    @(negedge clk); check("flush_first_stall", int'(pc_write), 0);
    next_cycle(); clr_hazard(); flush = 1;
    @(negedge clk); check("flush_pc_write", int'(pc_write), 1);
    check("flush_bubble", int'(id_ex_bubble), 0);
    next_cycle(); flush = 0;
    @(negedge clk); check("flush_idle_pc", int'(pc_write), 1);
    check("flush_stall_count", int'(stall_count), 1);

    // flush beats a simultaneous hazard
    next_cycle(); set_hazard(); flush = 1;
    @(negedge clk); check("flush_vs_hazard", int'(pc_write), 1);
    next_cycle(); clr_hazard(); flush = 0;

    // reset mid-stall releases asynchronously
    next_cycle(); set_hazard();
    next_cycle(); clr_hazard();
    @(negedge clk); check("rst_in_stall", int'(pc_write), 0);
    #1 reset = 1;
    #1;
    check("rst_async_pc", int'(pc_write), 1);
    check("rst_async_count", int'(stall_count), 0);
    #1 reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("rst_no_residual", int'(pc_write), 1);
    end
    check("rst_count_zero", int'(stall_count), 0);

    // saturation
    next_cycle(); set_hazard();
    repeat (65540) @(posedge clk);
    @(negedge clk); check("sat_count", int'(stall_count), 16'hFFFF);
    check("sat_still_stalled", int'(pc_write), 0);
    next_cycle(); clr_hazard();
    repeat (4) @(posedge clk);
    @(negedge clk); check("sat_hold", int'(stall_count), 16'hFFFF);
    check("sat_released", int'(pc_write), 1);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
